// File: rtl/elevator_ctrl.sv
// Elevator floor controller driving an external BCD up/down counter.
// Accepts one floor request at a time in IDLE, pulses the counter enable
// every STEP_CYCLES cycles toward the target, then holds the door open for
// DWELL_CYCLES cycles before accepting the next request.
module elevator_ctrl #(
  parameter int STEP_CYCLES  = 3,
  parameter int DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_floor,
  output logic       req_ready,
  input  logic       home,
  input  logic [3:0] count,
  output logic       en,
  output logic       up_down,
  output logic       load,
  output logic [3:0] data,
  output logic       moving,
  output logic       door_open,
  output logic       arrived,
  output logic       req_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam logic [3:0] STEP_LAST  = 4'(STEP_CYCLES - 1);
  localparam logic [3:0] DWELL_LAST = 4'(DWELL_CYCLES - 1);
  localparam logic [3:0] MAX_FLOOR  = 4'd9;

  state_t     state, state_d;
  logic [3:0] step_q, step_d;
  logic [3:0] dwell_q, dwell_d;
  logic [3:0] target_q, target_d;
  logic       up_q, up_d;
  logic       arrived_q, arrived_d;
  logic       req_err_q, req_err_d;

  // Register all controller state; reset aborts any move or dwell in progress.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      step_q    <= '0;
      dwell_q   <= '0;
      target_q  <= '0;
      up_q      <= 1'b1;
      arrived_q <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      state     <= state_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      target_q  <= target_d;
      up_q      <= up_d;
      arrived_q <= arrived_d;
      req_err_q <= req_err_d;
    end
  end

  // Next-state, timer and strobe logic for the IDLE/MOVE/DWELL sequence.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state;
    step_d    = step_q;
    dwell_d   = dwell_q;
    target_d  = target_q;
    up_d      = up_q;
    arrived_d = 1'b0;
    req_err_d = 1'b0;
    en        = 1'b0;
    load      = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          // A request always beats home; an out-of-range floor is only flagged.
          if (req_floor > MAX_FLOOR) begin
            req_err_d = 1'b1;
          end else if (req_floor == count) begin
            state_d   = DWELL;
            dwell_d   = '0;
            arrived_d = 1'b1;
          end else begin
            target_d = req_floor;
            up_d     = (req_floor > count);
            step_d   = '0;
            state_d  = MOVE;
          end
        end else if (home) begin
          load = 1'b1;
        end
      end

      MOVE: begin
        // Arrival takes priority so the counter is never stepped past the
        // target, even when STEP_CYCLES is 1 and the timer is always due.
        if (count == target_q) begin
          state_d   = DWELL;
          dwell_d   = '0;
          arrived_d = 1'b1;
        end else if (step_q == STEP_LAST) begin
          en     = 1'b1;
          step_d = '0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end

      DWELL: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = IDLE;
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign moving    = (state == MOVE);
  assign door_open = (state == DWELL);
  assign up_down   = up_q;
  assign arrived   = arrived_q;
  assign req_err   = req_err_q;
  assign data      = '0;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl with a BCD up/down counter model.
// Expected strobe events (en, arrived, req_err, load) are queued with the
// cycle they must appear in when stimulus is driven, and popped by a monitor.
module tb_elevator_ctrl;

  localparam int STEP  = 3;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_floor;
  logic       req_ready;
  logic       home;
  logic [3:0] count = 4'd0;
  logic       en;
  logic       up_down;
  logic       load;
  logic [3:0] data;
  logic       moving;
  logic       door_open;
  logic       arrived;
  logic       req_err;

  typedef enum int {EV_NONE, EV_EN, EV_ARR, EV_ERR, EV_LOAD} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       val;
  } ev_t;

  ev_t        sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         dwell_seen = 0;
  int         move_seen = 0;
  int         arr_total = 0;
  bit         track_nine = 1'b0;
  bit         nine_seen = 1'b0;
  logic       preset_en = 1'b0;
  logic [3:0] preset_val = 4'd0;

  elevator_ctrl #(.STEP_CYCLES(STEP), .DWELL_CYCLES(DWELL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_ready (req_ready),
    .home      (home),
    .count     (count),
    .en        (en),
    .up_down   (up_down),
    .load      (load),
    .data      (data),
    .moving    (moving),
    .door_open (door_open),
    .arrived   (arrived),
    .req_err   (req_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // BCD up/down counter with synchronous load, plus a bench-side preset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preset_en)   count <= preset_val;
    else if (load)   count <= data;
    else if (en)     count <= up_down ? ((count == 4'd9) ? 4'd0 : count + 4'd1)
                                      : ((count == 4'd0) ? 4'd9 : count - 4'd1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_t k, input int v);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", int'(k), int'(EV_NONE));
    end else begin
      e = sb.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      check("event_cycle", cyc, e.cyc);
      check("event_value", v, e.val);
    end
  endtask

  // Monitor samples 1 time unit after the falling edge, clear of both
  // the active edge and the bench's input updates.
  always @(negedge clk) begin
    #1;
    if (door_open) dwell_seen++;
    if (moving)    move_seen++;
    if (arrived)   arr_total++;
    if (track_nine && count == 4'd9) nine_seen = 1'b1;
    if (en)      expect_ev(EV_EN, int'(up_down));
    if (arrived) expect_ev(EV_ARR, 0);
    if (req_err) expect_ev(EV_ERR, 0);
    if (load)    expect_ev(EV_LOAD, int'(data));
  end

  task automatic preset(input int start);
    @(negedge clk);
    preset_en  = 1'b1;
    preset_val = 4'(start);
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Preset the counter, present one request for a single cycle and queue the
  // events the controller must produce for it.
  task automatic start_request(input int start, input int floor, input bit with_home);
    int acc;
    int n;
    preset(start);
    dwell_seen = 0;
    move_seen  = 0;
    req_valid  = 1'b1;
    req_floor  = 4'(floor);
    home       = with_home;
    acc = cyc + 1;
    if (floor > 9) begin
      push(EV_ERR, acc, 0);
    end else if (floor == start) begin
      push(EV_ARR, acc, 0);
    end else begin
      n = (floor > start) ? floor - start : start - floor;
      for (int k = 1; k <= n; k++) push(EV_EN, acc + STEP * k - 1, (floor > start) ? 1 : 0);
      push(EV_ARR, acc + STEP * n + 1, 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    home      = 1'b0;
  endtask

  task automatic finish_request(input string name, input int start, input int floor);
    int waited;
    int n;
    waited = 0;
    do begin
      @(negedge clk);
      #2;
      waited++;
    end while (!(req_ready === 1'b1 && sb.size() == 0) && waited < 100);
    check({name, "_idle_reached"}, int'(req_ready === 1'b1 && sb.size() == 0), 1);
    n = (floor > start) ? floor - start : start - floor;
    check({name, "_door_cycles"}, dwell_seen, (floor > 9) ? 0 : DWELL);
    check({name, "_move_cycles"}, move_seen, (floor > 9 || n == 0) ? 0 : STEP * n + 1);
    check({name, "_final_count"}, int'(count), (floor > 9) ? start : floor);
  endtask

  initial begin
    int snap;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_floor = 4'd0;
    home      = 1'b0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #2;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_up_down", int'(up_down), 1);
    check("rst_en", int'(en), 0);
    check("rst_load", int'(load), 0);
    check("rst_data", int'(data), 0);
    check("rst_moving", int'(moving), 0);
    check("rst_door_open", int'(door_open), 0);
    check("rst_arrived", int'(arrived), 0);
    check("rst_req_err", int'(req_err), 0);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check("post_rst_req_ready", int'(req_ready), 1);

    // Upward move 2 -> 5.
    start_request(2, 5, 1'b0);
    finish_request("up_2_5", 2, 5);

    // Downward move 7 -> 0 with home asserted mid-move; must not wrap to 9.
    track_nine = 1'b1;
    nine_seen  = 1'b0;
    start_request(7, 0, 1'b0);
    home = 1'b1;
    repeat (6) @(negedge clk);
    home = 1'b0;
    finish_request("down_7_0", 7, 0);
    track_nine = 1'b0;
    check("down_never_nine", int'(nine_seen), 0);

    // Request for the current floor.
    start_request(4, 4, 1'b0);
    finish_request("same_4", 4, 4);

    // Out-of-range floors: error pulse only, direction untouched.
    snap = int'(up_down);
    start_request(3, 12, 1'b0);
    finish_request("err_12", 3, 12);
    check("err_12_up_down", int'(up_down), snap);
    start_request(3, 10, 1'b0);
    finish_request("err_10", 3, 10);
    check("err_10_up_down", int'(up_down), snap);

    // Home in IDLE: one load strobe with data 0.
    preset(6);
    home = 1'b1;
    push(EV_LOAD, cyc, 0);
    @(negedge clk);
    home = 1'b0;
    @(negedge clk);
    #2;
    check("home_count", int'(count), 0);
    check("home_queue_empty", sb.size(), 0);

    // Home coinciding with an accepted request: request wins, no load.
    start_request(3, 3, 1'b1);
    finish_request("home_vs_req", 3, 3);

    // Top floor boundary.
    start_request(8, 9, 1'b0);
    finish_request("up_8_9", 8, 9);

    // Reset mid-move aborts immediately with no later arrival.
    start_request(2, 8, 1'b0);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_en", int'(en), 0);
    check("abort_moving", int'(moving), 0);
    check("abort_door_open", int'(door_open), 0);
    check("abort_arrived", int'(arrived), 0);
    check("abort_req_err", int'(req_err), 0);
    check("abort_load", int'(load), 0);
    check("abort_up_down", int'(up_down), 1);
    check("abort_req_ready", int'(req_ready), 1);
    sb.delete();
    snap = arr_total;
    @(negedge clk);
    #3;
    reset = 1'b1;
    repeat (15) @(negedge clk);
    #2;
    check("abort_ready_after", int'(req_ready), 1);
    check("abort_no_arrival", arr_total, snap);
    check("abort_still_idle", int'(moving), 0);

    // Normal operation resumes after the abort.
    start_request(0, 1, 1'b0);
    finish_request("resume_0_1", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter STEP_CYCLES, default 3: clock cycles between successive counter enable pulses while moving; legal range 1..15.
REQ-002 Parameter DWELL_CYCLES, default 4: cycles door_open stays high after arrival; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  floor request present.
REQ-006 req_floor  input  4  requested floor, BCD digit 0..9.
REQ-007 req_ready  output  1  controller accepts a request this cycle.
REQ-008 home  input  1  force position to floor 0 through counter load.
REQ-009 count  input  4  current floor from the BCD up/down counter.
REQ-010 en  output  1  counter enable, one-cycle pulses only.
REQ-011 up_down  output  1  counter direction: 1 = up, 0 = down.
REQ-012 load  output  1  counter synchronous load strobe.
REQ-013 data  output  4  counter load value.
REQ-014 moving  output  1  high while in MOVE.
REQ-015 door_open  output  1  high while in DWELL.
REQ-016 arrived  output  1  one-cycle pulse on arrival at the target.
REQ-017 req_err  output  1  one-cycle pulse when an accepted req_floor is greater than 9.

Function
REQ-018 FSM states: IDLE, MOVE, DWELL; req_ready = 1 only in IDLE.
REQ-019 A request is accepted on a rising edge with req_valid = 1 and req_ready = 1.
REQ-020 On acceptance with req_floor > 9: pulse req_err next cycle, remain in IDLE, latch nothing.
REQ-021 On acceptance with req_floor == count: pulse arrived next cycle and enter DWELL directly; en never asserted.
REQ-022 Otherwise: latch target = req_floor, set up_down = (req_floor > count) registered, clear step timer, enter MOVE.
REQ-023 In MOVE, the step timer counts 0..STEP_CYCLES-1; en = 1 for exactly one cycle when the timer equals STEP_CYCLES-1, then the timer restarts at 0.
REQ-024 In MOVE, up_down stays constant; first en occurs STEP_CYCLES cycles after entry.
REQ-025 In MOVE, when count == target and en is not asserted that cycle: next edge enters DWELL, arrived pulses one cycle, en = 0.
REQ-026 The counter never wraps under this controller: direction is chosen toward the target and the target is 0..9.
REQ-027 In DWELL, a dwell timer runs DWELL_CYCLES cycles with door_open = 1, then the FSM returns to IDLE.
REQ-028 home = 1 in IDLE with no request accepted that cycle: load = 1 for one cycle, data = 0.
REQ-029 home is ignored in MOVE and DWELL.
REQ-030 If home and an accepted request coincide in IDLE, the request wins and load stays 0.
REQ-031 data = 0 at all times; load is the only means of repositioning.
REQ-032 Requests presented outside IDLE are not accepted and have no effect; the requester holds req_valid.

Reset
REQ-033 reset low asynchronously forces state IDLE, both timers 0, target 0, up_down 1, and en, load, moving, door_open, arrived, req_err 0.
REQ-034 After reset, req_ready is 1.
REQ-035 Reset asserted mid-MOVE or mid-DWELL aborts the operation immediately; no arrived pulse follows.

Verification
REQ-036 count=2, request 5, STEP_CYCLES=3 -> up_down=1; en pulses at cycles 3, 6, 9 after acceptance; arrived one cycle after count reaches 5; door_open for 4 cycles; then req_ready=1.
REQ-037 count=7, request 0 -> up_down=0; 7 en pulses; arrived once; counter never shows 9.
REQ-038 count=4, request 4 -> no en; arrived next cycle; DWELL entered.
REQ-039 request 12 -> req_err pulse; state stays IDLE; outputs otherwise unchanged.
REQ-040 home pulse in IDLE -> load=1 for one cycle with data=0; home during MOVE -> load stays 0.
REQ-041 reset pulled low during MOVE -> all outputs at reset values immediately; req_ready=1 after release; no arrived pulse.
